// File: rtl/weight_feeder_if.sv
// weight_feeder_if: burst control, weight-memory read port and PE-array handshake of weight_feeder.
// WEIGHT_FEEDER_REPEAT_EN adds the repeat_cnt control input.
interface weight_feeder_if #(
    parameter int RD_ADDR_DEPTH = 8,
    parameter int DATA_WIDTH    = 64
);
    logic                     start;
    logic [RD_ADDR_DEPTH-1:0] base_addr;
    logic [RD_ADDR_DEPTH:0]   burst_len;
`ifdef WEIGHT_FEEDER_REPEAT_EN
    logic [7:0]               repeat_cnt;
`endif
    logic                     mem_rd_en;
    logic [RD_ADDR_DEPTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic [DATA_WIDTH-1:0]    w_data;
    logic                     w_valid;
    logic                     w_ready;
    logic                     busy;
    logic                     done;
`ifdef WEIGHT_FEEDER_REPEAT_EN
    modport master (
        output start, base_addr, burst_len, repeat_cnt, mem_rdata, w_ready,
        input  mem_rd_en, mem_addr, w_data, w_valid, busy, done
    );
    modport slave (
        input  start, base_addr, burst_len, repeat_cnt, mem_rdata, w_ready,
        output mem_rd_en, mem_addr, w_data, w_valid, busy, done
    );
`else
    modport master (
        output start, base_addr, burst_len, mem_rdata, w_ready,
        input  mem_rd_en, mem_addr, w_data, w_valid, busy, done
    );
    modport slave (
        input  start, base_addr, burst_len, mem_rdata, w_ready,
        output mem_rd_en, mem_addr, w_data, w_valid, busy, done
    );
`endif
endinterface

// File: rtl/weight_feeder.sv
// weight_feeder: streams burst_len weight words from a 1-cycle-latency memory to the PE array.
// WEIGHT_FEEDER_REPEAT_EN replays the burst repeat_cnt+1 times before completing.
module weight_feeder #(
    parameter int RD_ADDR_DEPTH = 8,
    parameter int DATA_WIDTH    = 64
) (
    input  logic           clk,
    input  logic           rst,
    weight_feeder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;
    state_t                   r_state;
    logic [RD_ADDR_DEPTH-1:0] r_addr;
    logic [RD_ADDR_DEPTH:0]   r_rd_left;
    logic                     r_inflight;
    logic [DATA_WIDTH-1:0]    r_buf [2];
    logic                     r_wp;
    logic                     r_rp;
    logic [1:0]               r_cnt;
    logic                     w_pop;
    logic                     w_rd;
    logic [1:0]               w_occ_next;
`ifdef WEIGHT_FEEDER_REPEAT_EN
    logic [RD_ADDR_DEPTH-1:0] r_base;
    logic [RD_ADDR_DEPTH:0]   r_len;
    logic [7:0]               r_rep;
`endif
    // Reads in flight are counted against buffer space so the 2-entry buffer can never overflow.
    assign w_pop      = (r_cnt != 2'd0) && bus.w_ready;
    assign w_occ_next = r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_rd       = (r_state == FETCH) && (w_occ_next < 2'd2);
    assign bus.mem_rd_en = w_rd;
    assign bus.mem_addr  = r_addr;
    assign bus.w_data    = r_buf[r_rp];
    assign bus.w_valid   = r_cnt != 2'd0;
    assign bus.busy      = (r_state == FETCH) || (r_state == DRAIN);
    assign bus.done      = r_state == FIN;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf      <= '{default: '0};
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_cnt      <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd;
            r_cnt      <= w_occ_next;
            if (r_inflight) begin
                r_buf[r_wp] <= bus.mem_rdata;
                r_wp        <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_rd_left <= '0;
`ifdef WEIGHT_FEEDER_REPEAT_EN
            r_base    <= '0;
            r_len     <= '0;
            r_rep     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_addr    <= bus.base_addr;
                    r_rd_left <= bus.burst_len;
`ifdef WEIGHT_FEEDER_REPEAT_EN
                    r_base    <= bus.base_addr;
                    r_len     <= bus.burst_len;
                    r_rep     <= bus.repeat_cnt;
`endif
                    r_state   <= (bus.burst_len != '0) ? FETCH : FIN;
                end
                FETCH: if (w_rd) begin
                    r_addr    <= r_addr + RD_ADDR_DEPTH'(1);
                    r_rd_left <= r_rd_left - (RD_ADDR_DEPTH+1)'(1);
                    if (r_rd_left == (RD_ADDR_DEPTH+1)'(1)) begin
`ifdef WEIGHT_FEEDER_REPEAT_EN
                        // Rewinding on the last read keeps replays back-to-back.
                        if (r_rep != 8'd0) begin
                            r_addr    <= r_base;
                            r_rd_left <= r_len;
                            r_rep     <= r_rep - 8'd1;
                        end else begin
                            r_state <= DRAIN;
                        end
`else
                        r_state <= DRAIN;
`endif
                    end
                end
                // No reads are issued in DRAIN, so the final word is the lone buffered one.
                DRAIN: if (w_pop && r_cnt == 2'd1 && !r_inflight) r_state <= FIN;
                FIN: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_feeder.sv
// tb_weight_feeder: vector table, reset corner sequences and random bursts against a memory reference model.
module tb_weight_feeder;
    localparam int AW = 8;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    weight_feeder_if #(.RD_ADDR_DEPTH(AW), .DATA_WIDTH(DW)) bus ();
    weight_feeder #(.RD_ADDR_DEPTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [DW-1:0] mem [256];
    int cyc;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.mem_rdata <= bus.mem_rd_en ? mem[bus.mem_addr] : {$urandom, $urandom};

    typedef struct {
        int base; int len; int rep; int rmode; int poke;
        int e_rd; int e_v; int e_done;
    } vec_t;
    vec_t vecs[$];

    int n_chk, n_pass;
    int t0;
    logic [AW-1:0] rd_q[$];
    logic [DW-1:0] hs_q[$];
    int hs_cyc[$];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    int first_rd, first_v, done_cnt, done_cyc, stall_err, ostd_err, ctl_err;
    logic prev_stall;
    logic [DW-1:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic clear_mon();
        rd_q.delete(); hs_q.delete(); hs_cyc.delete();
        first_rd = -1; first_v = -1; done_cnt = 0; done_cyc = -1;
        stall_err = 0; ostd_err = 0; ctl_err = 0; prev_stall = 1'b0;
    endtask

    task automatic monitor();
        forever begin
            int rel;
            @(negedge clk);
            rel = cyc - t0;
            if (bus.mem_rd_en) begin
                rd_q.push_back(bus.mem_addr);
                if (first_rd < 0) first_rd = rel;
                if (!bus.busy) ctl_err++;
            end
            if (prev_stall && !(bus.w_valid && bus.w_data == prev_data)) stall_err++;
            if (bus.w_valid && first_v < 0) first_v = rel;
            if (bus.w_valid && bus.w_ready) begin
                hs_q.push_back(bus.w_data);
                hs_cyc.push_back(rel);
            end
            if (rd_q.size() - hs_q.size() > 2) ostd_err++;
            if (bus.done) begin
                done_cnt++;
                done_cyc = rel;
                if (bus.busy) ctl_err++;
            end
            prev_stall = bus.w_valid && !bus.w_ready;
            prev_data  = bus.w_data;
        end
    endtask

    task automatic run_burst(input int base, input int len, input int rep, input int rmode, input int poke);
        @(posedge clk); #1;
        clear_mon();
        t0 = cyc;
        bus.start = 1'b1;
        bus.base_addr = AW'(base);
        bus.burst_len = (AW+1)'(len);
`ifdef WEIGHT_FEEDER_REPEAT_EN
        bus.repeat_cnt = 8'(rep);
`endif
        bus.w_ready = rmode != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int i = 1; i < 3000 && done_cnt == 0; i++) begin
            @(posedge clk); #1;
            bus.start = (poke != 0 && i == 2);
            if (bus.start) begin
                bus.base_addr = AW'($urandom);
                bus.burst_len = (AW+1)'(5);
            end
            bus.w_ready = rmode != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        bus.start = 1'b0;
        check("done_seen", 64'(done_cnt != 0), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Expected stream: rep+1 passes over base..base+len-1, addresses wrapping at 256.
    task automatic verify(input string tag, input int base, input int len, input int rep, input int rmode,
                          input int e_rd, input int e_v, input int e_done);
        int bad;
        logic [AW-1:0] a;
        exp_addr.delete(); exp_data.delete();
        for (int p = 0; p <= rep; p++)
            for (int i = 0; i < len; i++) begin
                a = AW'(base + i);
                exp_addr.push_back(a);
                exp_data.push_back(mem[a]);
            end
        check({tag, "/rd_count"}, 64'(rd_q.size()), 64'(exp_addr.size()));
        bad = 0;
        for (int i = 0; i < rd_q.size() && i < exp_addr.size(); i++) if (rd_q[i] != exp_addr[i]) bad++;
        check({tag, "/addr_order"}, 64'(bad), 64'd0);
        check({tag, "/word_count"}, 64'(hs_q.size()), 64'(exp_data.size()));
        bad = 0;
        for (int i = 0; i < hs_q.size() && i < exp_data.size(); i++) if (hs_q[i] != exp_data[i]) bad++;
        check({tag, "/word_data"}, 64'(bad), 64'd0);
        check({tag, "/done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "/stall_stable"}, 64'(stall_err), 64'd0);
        check({tag, "/outstanding"}, 64'(ostd_err), 64'd0);
        check({tag, "/ctl_excl"}, 64'(ctl_err), 64'd0);
        check({tag, "/first_rd"}, 64'(first_rd), 64'(e_rd));
        check({tag, "/first_valid"}, 64'(first_v), 64'(e_v));
        if (e_done >= 0) check({tag, "/done_cycle"}, 64'(done_cyc), 64'(e_done));
        if (rmode == 0 && len > 0) begin
            bad = 0;
            for (int i = 0; i < hs_cyc.size(); i++) if (hs_cyc[i] != 3 + i) bad++;
            check({tag, "/throughput"}, 64'(bad), 64'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        vecs.push_back('{'h10, 4, 0, 0, 0, 1, 3, 7});
        vecs.push_back('{'hFE, 4, 0, 0, 0, 1, 3, 7});
        vecs.push_back('{'h00, 0, 0, 0, 0, -1, -1, 1});
        vecs.push_back('{'h33, 1, 0, 0, 1, 1, 3, 4});
        vecs.push_back('{'hFF, 2, 0, 0, 0, 1, 3, 5});
        vecs.push_back('{'hF8, 256, 0, 0, 0, 1, 3, 259});
        vecs.push_back('{'h80, 16, 0, 1, 1, 1, 3, -1});
`ifdef WEIGHT_FEEDER_REPEAT_EN
        vecs.push_back('{'h20, 3, 1, 0, 0, 1, 3, 9});
        vecs.push_back('{'hFD, 5, 2, 1, 1, 1, 3, -1});
`endif
        clear_mon();
        t0 = 0;
        fork monitor(); join_none
        // Reset held together with a start request: reset must win.
        rst = 1'b1;
        bus.start = 1'b1; bus.base_addr = 8'h55; bus.burst_len = 9'd4; bus.w_ready = 1'b1;
`ifdef WEIGHT_FEEDER_REPEAT_EN
        bus.repeat_cnt = 8'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.start = 1'b0;
        check("reset/busy", 64'(bus.busy), 64'd0);
        check("reset/done", 64'(bus.done), 64'd0);
        check("reset/mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
        check("reset/w_valid", 64'(bus.w_valid), 64'd0);
        check("reset/mem_addr", 64'(bus.mem_addr), 64'd0);
        check("reset/w_data", bus.w_data, 64'd0);
        @(posedge clk); #1;
        check("reset/still_idle", 64'(bus.busy), 64'd0);

        foreach (vecs[k]) begin
            run_burst(vecs[k].base, vecs[k].len, vecs[k].rep, vecs[k].rmode, vecs[k].poke);
            verify($sformatf("vec%0d", k), vecs[k].base, vecs[k].len, vecs[k].rep, vecs[k].rmode,
                   vecs[k].e_rd, vecs[k].e_v, vecs[k].e_done);
        end

        // Abort a len-8 burst with reset in cycle 5; the read returning in cycle 6 must vanish.
        @(posedge clk); #1;
        t0 = cyc;
        bus.start = 1'b1; bus.base_addr = 8'h40; bus.burst_len = 9'd8; bus.w_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort/busy_before", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort/mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
        check("abort/w_valid", 64'(bus.w_valid), 64'd0);
        check("abort/busy", 64'(bus.busy), 64'd0);
        check("abort/done", 64'(bus.done), 64'd0);
        check("abort/mem_addr", 64'(bus.mem_addr), 64'd0);
        check("abort/w_data", bus.w_data, 64'd0);
        @(posedge clk); #1;
        check("abort/late_data_dropped", 64'(bus.w_valid), 64'd0);
        run_burst('h40, 8, 0, 0, 0);
        verify("after_abort", 'h40, 8, 0, 0, 1, 3, 11);

        for (int r = 0; r < 8; r++) begin
            int b, l, rp;
            b = $urandom_range(0, 255);
            l = $urandom_range(1, 24);
            rp = 0;
`ifdef WEIGHT_FEEDER_REPEAT_EN
            rp = $urandom_range(0, 2);
`endif
            run_burst(b, l, rp, 1, r % 2);
            verify($sformatf("rand%0d", r), b, l, rp, 1, 1, 3, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/weight_feeder.md
WEIGHT_FEEDER -- requirements
Module: weight_feeder

Interface
REQ-001 The module SHALL have parameter RD_ADDR_DEPTH, default 8; it is the weight memory read address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 64; it is the weight word width.
REQ-003 The module SHALL have port clk, input, 1 bit; it is the single clock, and all logic SHALL be on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit; it is a synchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit; it is a burst request pulse.
REQ-006 The module SHALL have port base_addr, input, RD_ADDR_DEPTH bits; it is the first read address, sampled on start.
REQ-007 The module SHALL have port burst_len, input, RD_ADDR_DEPTH+1 bits; it is the number of words to read, sampled on start.
REQ-008 The module SHALL have port mem_rd_en, output, 1 bit; it is the weight memory read strobe.
REQ-009 The module SHALL have port mem_addr, output, RD_ADDR_DEPTH bits; it is the weight memory read address.
REQ-010 The module SHALL have port mem_rdata, input, DATA_WIDTH bits; it is the read data, valid exactly 1 cycle after mem_rd_en.
REQ-011 The module SHALL have port w_data, output, DATA_WIDTH bits; it is the weight word to the PE array.
REQ-012 The module SHALL have port w_valid, output, 1 bit; it indicates that w_data is valid.
REQ-013 The module SHALL have port w_ready, input, 1 bit; it is the PE array acceptance signal, and a transfer SHALL occur when w_valid and w_ready are both high.
REQ-014 The module SHALL have port busy, output, 1 bit; it indicates that a burst is in progress.
REQ-015 The module SHALL have port done, output, 1 bit; it is a 1-cycle burst completion pulse.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, DRAIN and FIN.
REQ-017 IDLE -> FETCH SHALL occur when start=1 and burst_len!=0; IDLE -> FIN SHALL occur when start=1 and burst_len==0.
REQ-018 FETCH -> DRAIN SHALL occur in the cycle the last read is issued; DRAIN -> FIN SHALL occur on the last w handshake; FIN -> IDLE SHALL occur unconditionally.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 mem_addr SHALL begin at base_addr, increment by 1 per issued read, and wrap modulo 2^RD_ADDR_DEPTH (0xFF -> 0x00 at default).
REQ-021 Exactly burst_len reads SHALL be issued per burst, and exactly burst_len handshakes SHALL be produced, in address order.
REQ-022 An internal 2-entry buffer SHALL capture mem_rdata; in FETCH, a read SHALL be issued iff (occupancy + in-flight - pop_this_cycle) < 2.
REQ-023 The buffer SHALL never overflow, and no word SHALL be dropped or duplicated under any w_ready pattern.
REQ-024 Latency: with start in cycle 0, the first mem_rd_en SHALL be in cycle 1 and the first w_valid in cycle 3.
REQ-025 With w_ready held high, throughput SHALL be 1 word/cycle.
REQ-026 w_valid SHALL NOT drop, and w_data SHALL NOT change, while w_valid=1 and w_ready=0.
REQ-027 busy SHALL be 1 from the cycle after start is accepted until FIN, and SHALL be 0 in FIN.
REQ-028 done SHALL be 1 only in FIN.
REQ-029 mem_rd_en SHALL be 0 outside FETCH.

Reset
REQ-030 When rst=1 at a clock edge, the FSM SHALL go to IDLE and the buffer and in-flight count SHALL be cleared.
REQ-031 After reset, mem_rd_en, w_valid, busy and done SHALL be 0, and mem_addr and w_data SHALL be 0.
REQ-032 Reset mid-burst SHALL abort the burst, and read data returning in the following cycle SHALL be discarded.
REQ-033 rst SHALL take priority over start in the same cycle.

Configuration
REQ-034 The macro WEIGHT_FEEDER_REPEAT_EN SHALL be the only configuration macro.
REQ-035 When WEIGHT_FEEDER_REPEAT_EN is defined, an input repeat_cnt (8 bits, sampled on start) SHALL be added, and the burst SHALL be replayed repeat_cnt+1 times from base_addr before FIN.
REQ-036 When WEIGHT_FEEDER_REPEAT_EN is defined, each replay SHALL be seamless, with no idle cycle between replays when w_ready=1.
REQ-037 When WEIGHT_FEEDER_REPEAT_EN is not defined, the repeat_cnt port SHALL be absent, and the module SHALL behave as a single pass.

Verification
REQ-038 Stimulus: base_addr=0x10, burst_len=4, w_ready=1. Required response: w_data = mem[0x10..0x13] in cycles 3-6, done in cycle 7.
REQ-039 Stimulus: base_addr=0xFE, burst_len=4. Required response: addresses 0xFE, 0xFF, 0x00, 0x01 in that order.
REQ-040 Stimulus: burst_len=16 with w_ready random at 50%. Required response: 16 words in order, w_data stable while stalled, at most 2 reads outstanding.
REQ-041 Stimulus: burst_len=0. Required response: done in cycle 1, with no mem_rd_en and no w_valid.
REQ-042 Stimulus: rst asserted in cycle 5 of a burst_len=8 burst. Required response: in the next cycle all outputs are 0 and the state is IDLE; a new start then completes normally.
REQ-043 Stimulus (WEIGHT_FEEDER_REPEAT_EN defined): burst_len=3, repeat_cnt=1, w_ready=1. Required response: 6 words A0 A1 A2 A0 A1 A2 on consecutive cycles, then one done pulse.
